// File: rtl/sram_bus_sequencer.sv
// sram_bus_sequencer
// Turns single-word read/write requests into SRAM bus cycles for a 32K x 8
// asynchronous-style SRAM. Setup, strobe and hold lengths are set by
// parameters and counted in CLK cycles. Every pin-side signal, including the
// IO drive enable, comes straight from a flop, so request inputs never reach
// the pins combinationally.
module sram_bus_sequencer #(
    parameter int T_SETUP = 1,   // cycles with nCS low before the strobe, 1..15
    parameter int T_PULSE = 2,   // cycles with nOE/nWE low, 2..15
    parameter int T_HOLD  = 1    // cycles with nCS low after the strobe, 0..15
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [14:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        busy,
    output logic [14:0] A,
    output logic        nCS,
    output logic        nOE,
    output logic        nWE,
    inout  wire  [7:0]  IO
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // Counter reload values: the counter runs down to zero, so a phase of
    // N cycles loads N-1 on entry.
    localparam logic [3:0] CNT_SETUP = 4'(T_SETUP - 1);
    localparam logic [3:0] CNT_PULSE = 4'(T_PULSE - 1);
    localparam logic [3:0] CNT_HOLD  = (T_HOLD > 0) ? 4'(T_HOLD - 1) : 4'd0;

    // Timing parameters outside the counter range are a configuration error.
    // A pulse shorter than two cycles would capture read data before the
    // SRAM has produced it.
    generate
        if (T_SETUP < 1 || T_SETUP > 15) begin : g_bad_setup
            $error("sram_bus_sequencer: T_SETUP must be in 1..15");
        end
        if (T_PULSE < 2 || T_PULSE > 15) begin : g_bad_pulse
            $error("sram_bus_sequencer: T_PULSE must be in 2..15");
        end
        if (T_HOLD < 0 || T_HOLD > 15) begin : g_bad_hold
            $error("sram_bus_sequencer: T_HOLD must be in 0..15");
        end
    endgenerate

    logic [1:0]  state_reg;
    logic [3:0]  cnt_reg;
    logic        we_reg;
    logic [7:0]  wdata_reg;
    logic [14:0] addr_reg;
    logic        ncs_reg;
    logic        noe_reg;
    logic        nwe_reg;
    logic        io_oe_reg;
    logic        rsp_valid_reg;
    logic [7:0]  rdata_reg;

    // Sequencer: the state, the counter and every pin-side register advance
    // together, so each pin changes on the same edge as the state it belongs to.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 4'd0;
            we_reg        <= 1'b0;
            wdata_reg     <= 8'h00;
            addr_reg      <= 15'd0;
            ncs_reg       <= 1'b1;
            noe_reg       <= 1'b1;
            nwe_reg       <= 1'b1;
            io_oe_reg     <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rdata_reg     <= 8'h00;
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_reg  <= req_addr;
                        wdata_reg <= req_wdata;
                        we_reg    <= req_we;
                        ncs_reg   <= 1'b0;
                        // Writes drive data from the first setup cycle on.
                        io_oe_reg <= req_we;
                        cnt_reg   <= CNT_SETUP;
                        state_reg <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_reg == 4'd0) begin
                        if (we_reg) begin
                            nwe_reg <= 1'b0;
                        end else begin
                            noe_reg <= 1'b0;
                        end
                        cnt_reg   <= CNT_PULSE;
                        state_reg <= ST_PULSE;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ST_PULSE: begin
                    if (cnt_reg == 4'd0) begin
                        noe_reg       <= 1'b1;
                        nwe_reg       <= 1'b1;
                        rsp_valid_reg <= 1'b1;
                        // Last strobe edge: the SRAM output has had one full
                        // edge to settle since it registered the address.
                        if (!we_reg) begin
                            rdata_reg <= IO;
                        end
                        if (T_HOLD == 0) begin
                            ncs_reg   <= 1'b1;
                            io_oe_reg <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else begin
                            cnt_reg   <= CNT_HOLD;
                            state_reg <= ST_HOLD;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_reg == 4'd0) begin
                        ncs_reg   <= 1'b1;
                        io_oe_reg <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-bit tristate driver; the enable is only ever set for writes.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_io
            assign IO[gi] = io_oe_reg ? wdata_reg[gi] : 1'bz;
        end
    endgenerate

    assign req_ready = (state_reg == ST_IDLE);
    assign busy      = (state_reg != ST_IDLE);
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rdata_reg;
    assign A         = addr_reg;
    assign nCS       = ncs_reg;
    assign nOE       = noe_reg;
    assign nWE       = nwe_reg;

endmodule

// File: tb/tb_sram_bus_sequencer.sv
// Bench for sram_bus_sequencer: three instances with default (1/2/1),
// zero-hold (1/2/0) and maximum (15/15/15) timing, each attached to its own
// behavioural 32K x 8 SRAM.
`timescale 1ns/1ps
module tb_sram_bus_sequencer;

    localparam int NCH = 3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        req_valid [NCH];
    logic        req_ready [NCH];
    logic        req_we    [NCH];
    logic [14:0] req_addr  [NCH];
    logic [7:0]  req_wdata [NCH];
    logic        rsp_valid [NCH];
    logic [7:0]  rsp_rdata [NCH];
    logic        busy      [NCH];
    logic [14:0] A         [NCH];
    logic        ncs       [NCH];
    logic        noe       [NCH];
    logic        nwe       [NCH];
    logic [7:0]  io_val    [NCH];
    logic        dut_oe    [NCH];
    logic [14:0] peek_addr [NCH];
    logic [7:0]  peek_data [NCH];

    always #5 CLK = ~CLK;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        localparam int S = (gi == 2) ? 15 : 1;
        localparam int P = (gi == 2) ? 15 : 2;
        localparam int H = (gi == 0) ? 1 : ((gi == 1) ? 0 : 15);
        wire  [7:0] io_bus;
        logic [7:0] mem [0:32767];
        logic [7:0] sram_q;

        sram_bus_sequencer #(.T_SETUP(S), .T_PULSE(P), .T_HOLD(H)) u_dut (
            .CLK       (CLK),
            .nRST      (nRST),
            .req_valid (req_valid[gi]),
            .req_ready (req_ready[gi]),
            .req_we    (req_we[gi]),
            .req_addr  (req_addr[gi]),
            .req_wdata (req_wdata[gi]),
            .rsp_valid (rsp_valid[gi]),
            .rsp_rdata (rsp_rdata[gi]),
            .busy      (busy[gi]),
            .A         (A[gi]),
            .nCS       (ncs[gi]),
            .nOE       (noe[gi]),
            .nWE       (nwe[gi]),
            .IO        (io_bus)
        );

        // SRAM model: registers the address on strobe edges, output one edge later.
        assign io_bus = (!ncs[gi] && !noe[gi]) ? sram_q : 8'bz;
        always @(posedge CLK) begin
            if (!ncs[gi] && !nwe[gi]) mem[A[gi]] <= io_bus;
            if (!ncs[gi] && !noe[gi]) sram_q <= mem[A[gi]];
        end

        assign io_val[gi]    = io_bus;
        assign dut_oe[gi]    = u_dut.io_oe_reg;
        assign peek_data[gi] = mem[peek_addr[gi]];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One transaction on channel ch, starting from IDLE. Cycle 1 is the
    // cycle after the accept edge; outputs are sampled at each falling edge.
    task automatic run_txn(input int ch, input logic we, input logic [14:0] addr,
                           input logic [7:0] wd,
                           output int ncs_len, output int strb_first, output int strb_len,
                           output int rv_cnt, output int rv_cyc, output logic [7:0] rv_data,
                           output int ready_cyc, output int io_bad);
        logic strb;
        ncs_len = 0; strb_first = 0; strb_len = 0; rv_cnt = 0; rv_cyc = 0;
        rv_data = 8'h00; ready_cyc = 0; io_bad = 0;
        @(negedge CLK);
        req_we[ch] = we; req_addr[ch] = addr; req_wdata[ch] = wd; req_valid[ch] = 1'b1;
        @(posedge CLK);
        #1 req_valid[ch] = 1'b0;
        for (int j = 1; j <= 100; j++) begin
            @(negedge CLK);
            strb = we ? !nwe[ch] : !noe[ch];
            if (A[ch] !== addr) io_bad++;
            if (!ncs[ch]) begin
                ncs_len++;
                if (we && (!dut_oe[ch] || io_val[ch] !== wd)) io_bad++;
            end else if (dut_oe[ch]) begin
                io_bad++;
            end
            if (!we && dut_oe[ch]) io_bad++;
            if (we ? !noe[ch] : !nwe[ch]) io_bad++;
            if (strb) begin
                if (strb_len == 0) strb_first = j;
                strb_len++;
            end
            if (rsp_valid[ch]) begin
                rv_cnt++;
                rv_cyc  = j;
                rv_data = rsp_rdata[ch];
            end
            if (req_ready[ch]) begin
                ready_cyc = j;
                break;
            end
        end
    endtask

    typedef struct {
        int          ch;
        logic        we;
        logic [14:0] addr;
        logic [7:0]  wd;
        int          e_ncs;
        int          e_sfirst;
        int          e_slen;
        int          e_rv;
        int          e_ready;
        logic [7:0]  e_rdata;
    } vec_t;

    vec_t vecs [8];

    int          r_ncs, r_sfirst, r_slen, r_rvcnt, r_rvcyc, r_ready, r_bad;
    logic [7:0]  r_rdata;
    logic        b_we   [4];
    logic [14:0] b_addr [4];
    logic [7:0]  b_wd   [4];
    logic [7:0]  b_exp  [4];
    int          bk, brun, bgap, bruns, brsp, bbad, rv_seen;
    bit          bin_run, bacc;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ch, we, addr, wdata, nCS len, strobe first, strobe len, rsp cycle, ready cycle, rdata
        vecs[0] = '{0, 1'b1, 15'h1234, 8'hA5,  4,  2,  2,  4,  5, 8'h00};
        vecs[1] = '{0, 1'b0, 15'h1234, 8'h00,  4,  2,  2,  4,  5, 8'hA5};
        vecs[2] = '{0, 1'b1, 15'h0001, 8'h77,  4,  2,  2,  4,  5, 8'hA5};
        vecs[3] = '{0, 1'b0, 15'h0001, 8'h00,  4,  2,  2,  4,  5, 8'h77};
        vecs[4] = '{1, 1'b1, 15'h2AAA, 8'h96,  3,  2,  2,  4,  4, 8'h00};
        vecs[5] = '{1, 1'b0, 15'h2AAA, 8'h00,  3,  2,  2,  4,  4, 8'h96};
        vecs[6] = '{2, 1'b1, 15'h0456, 8'h5A, 45, 16, 15, 31, 46, 8'h00};
        vecs[7] = '{2, 1'b0, 15'h0456, 8'h00, 45, 16, 15, 31, 46, 8'h5A};

        // Reset with random request inputs.
        nRST = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            req_valid[c] = 1'($urandom_range(0, 1));
            req_we[c]    = 1'($urandom_range(0, 1));
            req_addr[c]  = 15'($urandom);
            req_wdata[c] = 8'($urandom);
            peek_addr[c] = 15'd0;
        end
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("rst_ncs_%0d", c), ncs[c], 1);
            chk($sformatf("rst_noe_%0d", c), noe[c], 1);
            chk($sformatf("rst_nwe_%0d", c), nwe[c], 1);
            chk($sformatf("rst_io_drive_%0d", c), dut_oe[c], 0);
            chk($sformatf("rst_addr_%0d", c), A[c], 0);
            chk($sformatf("rst_ready_%0d", c), req_ready[c], 1);
            chk($sformatf("rst_busy_%0d", c), busy[c], 0);
            chk($sformatf("rst_rsp_valid_%0d", c), rsp_valid[c], 0);
            chk($sformatf("rst_rsp_rdata_%0d", c), rsp_rdata[c], 0);
            req_valid[c] = 1'b0;
        end
        $display("txn reset checked on all channels");
        nRST = 1'b1;
        repeat (2) @(negedge CLK);

        // Table-driven single transactions.
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].ch, vecs[i].we, vecs[i].addr, vecs[i].wd,
                    r_ncs, r_sfirst, r_slen, r_rvcnt, r_rvcyc, r_rdata, r_ready, r_bad);
            $display("txn %0d ch=%0d we=%0d addr=0x%04h wdata=0x%02h ncs_len=%0d strobe=%0d@%0d rsp@%0d rdata=0x%02h ready@%0d",
                     i, vecs[i].ch, vecs[i].we, vecs[i].addr, vecs[i].wd,
                     r_ncs, r_slen, r_sfirst, r_rvcyc, r_rdata, r_ready);
            chk($sformatf("v%0d_ncs_len", i), r_ncs, vecs[i].e_ncs);
            chk($sformatf("v%0d_strobe_first", i), r_sfirst, vecs[i].e_sfirst);
            chk($sformatf("v%0d_strobe_len", i), r_slen, vecs[i].e_slen);
            chk($sformatf("v%0d_rsp_count", i), r_rvcnt, 1);
            chk($sformatf("v%0d_rsp_cycle", i), r_rvcyc, vecs[i].e_rv);
            chk($sformatf("v%0d_ready_cycle", i), r_ready, vecs[i].e_ready);
            chk($sformatf("v%0d_bus_errors", i), r_bad, 0);
            chk($sformatf("v%0d_rsp_rdata", i), r_rdata, vecs[i].e_rdata);
            if (vecs[i].we) begin
                peek_addr[vecs[i].ch] = vecs[i].addr;
                #1;
                chk($sformatf("v%0d_sram_word", i), peek_data[vecs[i].ch], vecs[i].wd);
            end
        end

        // Back-to-back on the zero-hold channel with req_valid held high.
        b_we[0] = 1'b1; b_addr[0] = 15'h7FFF; b_wd[0] = 8'h3C; b_exp[0] = 8'h00;
        b_we[1] = 1'b1; b_addr[1] = 15'h0000; b_wd[1] = 8'hC3; b_exp[1] = 8'h00;
        b_we[2] = 1'b0; b_addr[2] = 15'h7FFF; b_wd[2] = 8'h00; b_exp[2] = 8'h3C;
        b_we[3] = 1'b0; b_addr[3] = 15'h0000; b_wd[3] = 8'h00; b_exp[3] = 8'hC3;
        bk = 0; brun = 0; bgap = 0; bruns = 0; brsp = 0; bbad = 0; bin_run = 1'b0;
        @(negedge CLK);
        req_we[1] = b_we[0]; req_addr[1] = b_addr[0]; req_wdata[1] = b_wd[0];
        req_valid[1] = 1'b1;
        for (int cyc = 0; cyc < 100 && brsp < 4; cyc++) begin
            if (!ncs[1]) begin
                if (!bin_run) begin
                    if (bruns > 0) chk($sformatf("b2b_gap_%0d", bruns), bgap, 1);
                    bin_run = 1'b1;
                    brun = 0;
                end
                brun++;
            end else begin
                if (bin_run) begin
                    chk($sformatf("b2b_ncs_len_%0d", bruns), brun, 3);
                    bruns++;
                    bin_run = 1'b0;
                    bgap = 0;
                end
                bgap++;
            end
            if (dut_oe[1] && (!noe[1] || ncs[1])) bbad++;
            if (rsp_valid[1]) begin
                if (!b_we[brsp]) chk($sformatf("b2b_rdata_%0d", brsp), rsp_rdata[1], b_exp[brsp]);
                $display("txn b2b %0d we=%0d addr=0x%04h rdata=0x%02h", brsp, b_we[brsp], b_addr[brsp], rsp_rdata[1]);
                brsp++;
            end
            bacc = req_valid[1] && req_ready[1];
            @(posedge CLK);
            #1;
            if (bacc) begin
                bk++;
                if (bk < 4) begin
                    req_we[1] = b_we[bk]; req_addr[1] = b_addr[bk]; req_wdata[1] = b_wd[bk];
                end else begin
                    req_valid[1] = 1'b0;
                end
            end
            @(negedge CLK);
        end
        chk("b2b_responses", brsp, 4);
        chk("b2b_accesses", bruns, 4);
        chk("b2b_contention", bbad, 0);

        // Reset during the strobe of a write.
        repeat (2) @(negedge CLK);
        req_we[0] = 1'b1; req_addr[0] = 15'h0010; req_wdata[0] = 8'hFF; req_valid[0] = 1'b1;
        @(posedge CLK);
        #1 req_valid[0] = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("midrst_strobe_active", nwe[0], 0);
        #2 nRST = 1'b0;
        #1;
        chk("midrst_nwe", nwe[0], 1);
        chk("midrst_ncs", ncs[0], 1);
        chk("midrst_io_drive", dut_oe[0], 0);
        chk("midrst_busy", busy[0], 0);
        rv_seen = 0;
        if (rsp_valid[0]) rv_seen++;
        repeat (2) begin
            @(negedge CLK);
            if (rsp_valid[0]) rv_seen++;
        end
        nRST = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            if (rsp_valid[0]) rv_seen++;
        end
        chk("midrst_no_rsp", rv_seen, 0);
        $display("txn reset during write strobe on ch0");

        run_txn(0, 1'b1, 15'h0010, 8'h11, r_ncs, r_sfirst, r_slen, r_rvcnt, r_rvcyc, r_rdata, r_ready, r_bad);
        $display("txn post-reset write addr=0x0010 wdata=0x11 ncs_len=%0d rsp@%0d", r_ncs, r_rvcyc);
        chk("post_w_ncs_len", r_ncs, 4);
        chk("post_w_rsp_count", r_rvcnt, 1);
        chk("post_w_rdata_cleared", r_rdata, 8'h00);
        chk("post_w_bus_errors", r_bad, 0);
        run_txn(0, 1'b0, 15'h0010, 8'h00, r_ncs, r_sfirst, r_slen, r_rvcnt, r_rvcyc, r_rdata, r_ready, r_bad);
        $display("txn post-reset read addr=0x0010 rdata=0x%02h", r_rdata);
        chk("post_r_rdata", r_rdata, 8'h11);
        chk("post_r_strobe_len", r_slen, 2);
        chk("post_r_bus_errors", r_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_bus_sequencer.md
# sram_bus_sequencer

Bus master that converts single-word read/write requests from the emulator core into asynchronous-style SRAM bus cycles (A, nCS, nOE, nWE, IO) for the 32K x 8 SRAM stage. Sits directly upstream of the SRAM emulation block and connects to its pins one-to-one. Programmable setup, strobe and hold lengths, counted in CLK cycles. Captures read data and guarantees the IO bus is never driven by both sides.

## Interface
- T_SETUP, 1, cycles with nCS low before the strobe; legal 1..15
- T_PULSE, 2, cycles with nOE or nWE low; legal 2..15
- T_HOLD, 1, cycles with nCS low after the strobe; legal 0..15
- CLK  in  1  single clock; all logic rises on this edge
- nRST  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request is accepted on an edge where valid and ready are both high
- req_we  in  1  1 = write, 0 = read
- req_addr  in  15  word address
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle pulse when a transaction's strobe ends
- rsp_rdata  out  8  read data; updated on reads only, held otherwise
- busy  out  1  high in any non-IDLE state
- A  out  15  SRAM address
- nCS  out  1  chip select, active low
- nOE  out  1  output enable, active low
- nWE  out  1  write enable, active low
- IO  inout  8  SRAM data bus

## Operation
- States: IDLE, SETUP, PULSE, HOLD. A 4-bit down-counter loads on each state entry.
- All SRAM-side outputs and the IO drive enable come from registers. There is no combinational path from req_* to the pins.
- IDLE:
  - nCS, nOE, nWE = 1; IO = Z; req_ready = 1.
  - On accept: latch addr, wdata and we; A takes the latched addr; go to SETUP.
- SETUP, for T_SETUP cycles:
  - nCS = 0; nOE = nWE = 1.
  - IO is driven with wdata on writes and Z on reads.
- PULSE, for T_PULSE cycles, nCS = 0:
  - Write: nWE = 0 and IO is driven.
  - Read: nOE = 0 and IO = Z.
  - Read capture: on the final PULSE edge, IO is sampled into rsp_rdata.
  - rsp_valid = 1 for the first cycle after PULSE, for both reads and writes.
- HOLD, for T_HOLD cycles:
  - nCS = 0; nOE = nWE = 1.
  - Write data stays driven through HOLD for hold time.
  - If T_HOLD = 0, go from PULSE directly to IDLE.
- Exit to IDLE: nCS returns to 1 and IO is released in the same cycle.
- A is held stable from the first SETUP cycle until the next accept. It is not cleared in IDLE.
- Contention rule: IO is never driven while nOE = 0, and never during a read. The drive enable drops on the same edge that ends a write.
- Back-to-back requests: req_ready is high only in IDLE, so there is at least one cycle with nCS high between transactions.
- req_valid while busy: ignored, no effect. The upstream block must hold req_valid until it is accepted.

## Timing
- Reset (async, nRST low):
  - State = IDLE; nCS = nOE = nWE = 1; A = 0; IO = Z.
  - req_ready = 1; busy = 0; rsp_valid = 0; rsp_rdata = 0.
  - Takes effect immediately, without waiting for CLK.
- Reset mid-transaction: strobes deassert and IO is released at once. The transaction is dropped and no rsp_valid is issued.
- With the accept on edge k, nCS is low for cycles k+1 .. k+T_SETUP+T_PULSE+T_HOLD.
- With the defaults (1/2/1):
  - nCS is low 4 cycles and the strobe is in cycles 2-3.
  - rsp_valid rises in cycle 4.
  - req_ready returns in cycle 5, giving a throughput of 5 cycles per access.
- Read latency: the SRAM registers its address on the first strobe edge, and q is valid one edge later. The capture on the last PULSE edge is therefore valid for T_PULSE ≥ 2.
- Out-of-range parameters are a configuration error. An elaboration-time check is required.

## Test plan
- Reset:
  - Assert nRST low with random inputs.
  - Required: nCS = nOE = nWE = 1, IO = Z, A = 0, req_ready = 1, rsp_valid = 0, rsp_rdata = 0.
- Single write, defaults:
  - Write 0xA5 to 0x1234.
  - Required: nCS low exactly 4 cycles; nWE low exactly in cycles 2-3; IO = 0xA5 in cycles 1-4 and Z afterwards; one rsp_valid pulse; SRAM word 0x1234 = 0xA5.
- Read-back:
  - Read 0x1234.
  - Required: nOE low 2 cycles; IO is never driven by the sequencer; rsp_rdata = 0xA5 when rsp_valid = 1.
- Back-to-back, boundaries, T_HOLD = 0:
  - Hold req_valid high and issue write 0x7FFF <- 0x3C, write 0x0000 <- 0xC3, read 0x7FFF, read 0x0000.
  - Required: exactly one nCS-high cycle between accesses; reads return 0x3C and 0xC3; nCS low exactly 3 cycles per access.
- Maximum timing:
  - Set T_SETUP = T_PULSE = T_HOLD = 15, then write and read.
  - Required: nCS low 45 cycles, strobe 15 cycles, read data correct.
- Reset mid-write:
  - Drop nRST during PULSE of a write 0x0010 <- 0xFF.
  - Required: nWE high and IO = Z with no clock edge needed; no rsp_valid; the next transaction after reset completes normally.
